// File: rtl/cfg_write_arbiter.sv
// Round-robin write arbiter for the five PWM configuration registers, with an optional
// shadow bank committed atomically to the active outputs (enabled by macro CFG_SHADOW_EN).
module cfg_write_arbiter #(
    parameter int DW = 8,
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_valid,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    input  logic          commit,
    output logic [DW-1:0] reg1,
    output logic [DW-1:0] reg2,
    output logic [DW-1:0] reg3,
    output logic [DW-1:0] reg4,
    output logic [DW-1:0] reg5,
    output logic          pending,
    output logic          err
);

    localparam int NREG = 5;

    typedef enum logic {IDLE, ACCEPT} state_t;

    state_t        state, state_nxt;
    logic          last_b;
    logic          grant_a, grant_b;
    logic          wr_en, wr_hit;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] active [NREG];

    function automatic logic addr_in_range(input logic [AW-1:0] addr);
        return addr < AW'(NREG);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // On a tie the requester that was not granted last wins
    always_comb begin
        state_nxt = state;
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        case (state)
            IDLE: begin
                if (a_valid || b_valid) begin
                    if (a_valid && (!b_valid || last_b)) grant_a = 1'b1;
                    else                                 grant_b = 1'b1;
                    state_nxt = ACCEPT;
                end
            end
            ACCEPT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        wr_en   = grant_a || grant_b;
        wr_addr = grant_a ? a_addr : b_addr;
        wr_data = grant_a ? a_data : b_data;
        wr_hit  = wr_en && addr_in_range(wr_addr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_ready <= 1'b0;
            b_ready <= 1'b0;
            err     <= 1'b0;
            last_b  <= 1'b1;
        end else begin
            a_ready <= grant_a;
            b_ready <= grant_b;
            err     <= wr_en && !wr_hit;
            if (wr_en) last_b <= grant_b;
        end
    end

`ifdef CFG_SHADOW_EN
    logic [DW-1:0] shadow [NREG];

    // Active copies the pre-write shadow, so a same-edge write stays pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            pending <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (commit) active[i] <= shadow[i];
                if (wr_hit && wr_addr == AW'(i)) shadow[i] <= wr_data;
            end
            if (wr_hit)      pending <= 1'b1;
            else if (commit) pending <= 1'b0;
        end
    end
`else
    logic unused_commit;
    assign unused_commit = commit;
    assign pending       = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) active[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wr_hit && wr_addr == AW'(i)) active[i] <= wr_data;
            end
        end
    end
`endif

    assign reg1 = active[0];
    assign reg2 = active[1];
    assign reg3 = active[2];
    assign reg4 = active[3];
    assign reg5 = active[4];

endmodule

// File: tb/tb_cfg_write_arbiter.sv
// Directed bench for cfg_write_arbiter: grant scoreboard plus a register model
// that follows whichever build (CFG_SHADOW_EN or direct) is compiled.
module tb_cfg_write_arbiter;

`ifdef CFG_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_valid = 1'b0, b_valid = 1'b0, commit = 1'b0;
    logic [6:0] a_addr = '0, b_addr = '0;
    logic [7:0] a_data = '0, b_data = '0;
    logic       a_ready, b_ready, pending, err;
    logic [7:0] reg1, reg2, reg3, reg4, reg5;

    cfg_write_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .commit(commit),
        .reg1(reg1), .reg2(reg2), .reg3(reg3), .reg4(reg4), .reg5(reg5),
        .pending(pending), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic is_a;
        logic err;
    } exp_t;

    exp_t       exp_q[$];
    int         total = 0;
    int         bad = 0;
    logic [7:0] m_sh [5];
    logic [7:0] m_act [5];
    logic       m_pend = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 5; i++) begin
            m_sh[i]  = 8'h00;
            m_act[i] = 8'h00;
        end
        m_pend = 1'b0;
    endfunction

    function automatic void model_write(input int addr, input logic [7:0] d);
        if (addr < 5) begin
            if (SHADOW) begin
                m_sh[addr] = d;
                m_pend     = 1'b1;
            end else begin
                m_act[addr] = d;
            end
        end
    endfunction

    function automatic void model_commit();
        if (SHADOW) begin
            for (int i = 0; i < 5; i++) m_act[i] = m_sh[i];
            m_pend = 1'b0;
        end
    endfunction

    // Advance one clock, then pop the scoreboard whenever a grant is visible
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (a_ready || b_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_ready", {30'd0, a_ready, b_ready}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("grant_a", a_ready, e.is_a);
                chk("grant_b", b_ready, !e.is_a);
                chk("err_on_grant", err, e.err);
            end
        end else begin
            chk("err_idle", err, 1'b0);
        end
    endtask

    task automatic wait_ready(input logic is_a, input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            tick();
            if (is_a ? a_ready : b_ready) seen = 1'b1;
        end
        chk(is_a ? "a_ready_timeout" : "b_ready_timeout", seen, 1'b1);
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_reg1"}, reg1, m_act[0]);
        chk({tag, "_reg2"}, reg2, m_act[1]);
        chk({tag, "_reg3"}, reg3, m_act[2]);
        chk({tag, "_reg4"}, reg4, m_act[3]);
        chk({tag, "_reg5"}, reg5, m_act[4]);
        chk({tag, "_pending"}, pending, m_pend);
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        model_commit();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_regs("reset");
        chk("reset_a_ready", a_ready, 1'b0);
        chk("reset_b_ready", b_ready, 1'b0);
        chk("reset_err", err, 1'b0);
        rst_n = 1'b1;

        // A writes addr 2 / 0x5A, visible only after commit in shadow mode
        a_valid = 1'b1; a_addr = 7'd2; a_data = 8'h5A;
        exp_q.push_back('{is_a: 1'b1, err: 1'b0});
        wait_ready(1'b1, 3);
        a_valid = 1'b0;
        model_write(2, 8'h5A);
        check_regs("t1_write");
        tick();
        chk("t1_a_ready_one_cycle", a_ready, 1'b0);
        check_regs("t1_hold");
        do_commit();
        check_regs("t1_commit");

        // B writes an out-of-range address
        b_valid = 1'b1; b_addr = 7'd7; b_data = 8'hFF;
        exp_q.push_back('{is_a: 1'b0, err: 1'b1});
        wait_ready(1'b0, 3);
        b_valid = 1'b0;
        check_regs("t3_bad_addr");
        tick();
        do_commit();
        check_regs("t3_commit");

        // Tie: A wins (B granted last), B two cycles later
        a_valid = 1'b1; a_addr = 7'd0; a_data = 8'h11;
        b_valid = 1'b1; b_addr = 7'd1; b_data = 8'h22;
        exp_q.push_back('{is_a: 1'b1, err: 1'b0});
        exp_q.push_back('{is_a: 1'b0, err: 1'b0});
        wait_ready(1'b1, 2);
        a_valid = 1'b0;
        tick();
        chk("tie_b_not_yet", b_ready, 1'b0);
        tick();
        chk("tie_b_at_plus2", b_ready, 1'b1);
        b_valid = 1'b0;
        model_write(0, 8'h11);
        model_write(1, 8'h22);
        tick();
        do_commit();
        check_regs("tie_commit");

        // Continuous contention: strictly alternating grants
        a_valid = 1'b1; a_addr = 7'd0; a_data = 8'h44;
        b_valid = 1'b1; b_addr = 7'd1; b_data = 8'h55;
        for (int i = 0; i < 6; i++)
            exp_q.push_back('{is_a: (i % 2 == 0), err: 1'b0});
        for (int i = 0; i < 12; i++) tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
        chk("alt_all_granted", exp_q.size(), 0);
        model_write(0, 8'h44);
        model_write(1, 8'h55);
        do_commit();
        check_regs("alt_commit");

        // Commit on the same edge as an A write to addr 4
        a_valid = 1'b1; a_addr = 7'd4; a_data = 8'h80;
        commit  = 1'b1;
        exp_q.push_back('{is_a: 1'b1, err: 1'b0});
        wait_ready(1'b1, 1);
        a_valid = 1'b0;
        commit  = 1'b0;
        model_commit();
        model_write(4, 8'h80);
        check_regs("same_edge");
        tick();
        do_commit();
        check_regs("same_edge_next_commit");

        // Reset in the ACCEPT cycle of a B write, B still holding valid
        b_valid = 1'b1; b_addr = 7'd3; b_data = 8'h77;
        exp_q.push_back('{is_a: 1'b0, err: 1'b0});
        wait_ready(1'b0, 2);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_regs("async_reset");
        chk("async_reset_b_ready", b_ready, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back('{is_a: 1'b0, err: 1'b0});
        wait_ready(1'b0, 1);
        b_valid = 1'b0;
        model_write(3, 8'h77);
        tick();
        do_commit();
        check_regs("regrant_commit");

        // After reset last_grant is B again, so A wins a tie
        a_valid = 1'b1; a_addr = 7'd0; a_data = 8'h3C;
        b_valid = 1'b1; b_addr = 7'd2; b_data = 8'h66;
        exp_q.push_back('{is_a: 1'b1, err: 1'b0});
        exp_q.push_back('{is_a: 1'b0, err: 1'b0});
        wait_ready(1'b1, 1);
        a_valid = 1'b0;
        model_write(0, 8'h3C);
        check_regs("direct_a_write");
        wait_ready(1'b0, 3);
        b_valid = 1'b0;
        model_write(2, 8'h66);
        check_regs("post_reset_b");
        tick();
        do_commit();
        check_regs("final_commit");
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cfg_write_arbiter.md
# cfg_write_arbiter

Two-port write arbiter and commit controller for the five 8-bit PWM configuration registers. Requester A is the SPI frame decoder and requester B is the on-chip sequencer. Writes are arbitrated round-robin, range-checked, and held in a shadow bank. The shadow bank is copied atomically to the active outputs on a `commit` pulse, normally the PWM period boundary. The active outputs drive the output-enable and PWM datapath directly.

## Interface
Parameters:
- `DW`, 8, register data width
- `AW`, 7, register address width

Ports:
- `clk`, in, 1: system clock; single clock domain
- `rst_n`, in, 1: reset, asynchronous, active-low
- `a_valid`, in, 1: requester A write request
- `a_addr`, in, AW: requester A register address
- `a_data`, in, DW: requester A write data
- `a_ready`, out, 1: requester A accept pulse
- `b_valid`, in, 1: requester B write request
- `b_addr`, in, AW: requester B register address
- `b_data`, in, DW: requester B write data
- `b_ready`, out, 1: requester B accept pulse
- `commit`, in, 1: one-cycle pulse that copies shadow to active
- `reg1` through `reg5`, out, DW each: active configuration registers at addresses 0–4
- `pending`, out, 1: shadow holds writes not yet committed
- `err`, out, 1: one-cycle pulse when an accepted write had addr ≥ 5

## Operation
- State machine has two states, IDLE and ACCEPT.
- **IDLE**
  - If either `valid` is sampled high at edge k, pick a winner, perform the write at edge k, and go to ACCEPT.
  - If neither is high, stay in IDLE.
- **ACCEPT**
  - Lasts exactly one cycle; both `valid` inputs are ignored.
  - Returns to IDLE at edge k+1.
- **Arbitration**
  - If only one requester is valid, it wins.
  - If both are valid, the winner is the requester not granted last.
  - The `last_grant` flag updates on every grant and resets to B, so A wins the first tie.
- **Write**
  - If addr < 5, `shadow[addr] <= data` and `pending <= 1`.
  - If addr ≥ 5, nothing is written and `err` pulses. The request is still acknowledged so the requester never stalls.
- **Handshake**
  - A requester holds `valid`, `addr` and `data` stable until it sees its `ready` high.
  - It must drop `valid` or present a new request on the following edge.
  - `ready` is registered and lasts exactly one cycle, and only the winner's `ready` rises.
  - The loser keeps `valid` high and is granted on the next IDLE cycle.
- **Commit**
  - At a commit edge, all five active registers are loaded from shadow in the same edge, and `pending <= 0`.
  - A commit with `pending` = 0 is harmless; active registers already equal shadow.
- **Commit and write on the same edge**
  - Active registers take the pre-write shadow value.
  - The new write lands in shadow.
  - `pending` ends at 1.
- **Reset**
  - Reset is valid at any time, including during ACCEPT, and clears everything asynchronously.
  - An in-flight request is not acknowledged; the requester still holding `valid` is re-arbitrated after reset release.

## Timing
- Reset values:
  - `reg1`–`reg5` = 0x00 and all shadow registers = 0x00.
  - `a_ready`, `b_ready`, `err`, `pending` = 0.
  - State is IDLE and `last_grant` is B.
- Accept latency: `valid` sampled at edge k, then `ready` and `err` are high from edge k to edge k+1.
- Throughput: one write per 2 cycles. With both requesters continuously valid, grants alternate A, B, A, B.
- Commit latency: outputs change at the edge that samples `commit` high; no extra pipeline stage.
- `pending` rises at the write edge k and falls at the commit edge.

## Configuration
- Macro `CFG_SHADOW_EN`.
- **Defined:** shadow bank and commit behave as described above.
- **Undefined:**
  - No shadow bank; accepted writes load the active register directly at edge k.
  - `commit` is ignored.
  - `pending` is tied to 0.
  - Arbitration, handshake, `err` and reset behaviour are unchanged.

## Test plan
- Reset, then A writes addr 2 / 0x5A, then `commit`:
  - `a_ready` pulses for 1 cycle and `pending` goes to 1.
  - `reg3` stays 0x00 until the commit edge, then becomes 0x5A and `pending` goes to 0.
- A and B both hold `valid`, with A at addr 0 / 0x11 and B at addr 1 / 0x22:
  - Grant order is A then B, 2 cycles apart.
  - After commit, `reg1` = 0x11 and `reg2` = 0x22.
  - Repeating the test with both continuously valid gives strictly alternating grants.
- B writes addr 7 / 0xFF:
  - `b_ready` and `err` pulse together.
  - No shadow change and `pending` stays 0.
- `commit` on the same edge as an A write of addr 4 / 0x80 over an old value of 0x00:
  - `reg5` = 0x00 and `pending` = 1.
  - The next commit gives `reg5` = 0x80.
- Assert `rst_n` low during ACCEPT of a B write, with `b_valid` still held:
  - All outputs go to 0 immediately.
  - After release, the B write is re-granted within 1 cycle.
- Build without `CFG_SHADOW_EN`, then A writes addr 0 / 0x3C:
  - `reg1` = 0x3C one edge later with no commit.
  - `pending` stays 0.
